ucie_ctl_sb_rx_packet_receiver: RTL

UCIE_CTL_SB_RX_PACKET_RECEIVER -- requirements
Module: UCIE_ctl_sb_rx_packet_receiver

---
 rtl/ucie_ctl_sb_rx_packet_receiver_pkg.sv | 18 +
 rtl/ucie_ctl_sb_rx_packet_receiver.sv | 90 +++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_rx_packet_receiver_pkg.sv
// Shared sideband constants for the RX packet receiver: lane width default,
// phase width and assembler state encoding.
package ucie_ctl_sb_rx_packet_receiver_pkg;

   localparam int unsigned SB_NC      = 8;
   localparam int unsigned SB_PHASE_W = 32;

   typedef enum logic {
      RX_IDLE     = 1'b0,
      RX_ASSEMBLE = 1'b1
   } rx_state_e;

   // Chunk counter width; a single-chunk phase still keeps a 1-bit counter.
   function automatic int unsigned chunk_cnt_w(input int unsigned chunks);
      return (chunks > 1) ? $clog2(chunks) : 1;
   endfunction

endpackage

// File: rtl/ucie_ctl_sb_rx_packet_receiver.sv
// Sideband RX packet receiver: gathers NC-bit chunks LSB-first into a 32-bit
// phase and holds it for the consumer until acknowledged.
module ucie_ctl_sb_rx_packet_receiver
   import ucie_ctl_sb_rx_packet_receiver_pkg::*;
#(
   parameter int unsigned NC = SB_NC   // legal values: 8, 16, 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NC-1:0]         i_rdi_pl_cfg,
   input  logic                  i_rdi_pl_cfg_vld,
   input  logic                  i_flush,
   input  logic                  i_phase_ack,
   output logic [SB_PHASE_W-1:0] o_phase_received,
   output logic                  o_phase_valid,
   output logic                  o_busy,
   output logic                  o_overrun
);

   localparam int unsigned CHUNKS = SB_PHASE_W / NC;
   localparam int unsigned CW     = chunk_cnt_w(CHUNKS);

   rx_state_e             state_q;
   logic [CW-1:0]         cnt_q;
   logic [SB_PHASE_W-1:0] partial_q;

   logic [SB_PHASE_W-1:0] phase_next_c;
   logic                  last_c;
   logic                  complete_c;

   // Merge the incoming chunk into its lane slot of the partial phase.
   always_comb begin
      phase_next_c = partial_q;
      for (int unsigned k = 0; k < CHUNKS; k++) begin
         if (cnt_q == CW'(k)) begin
            phase_next_c[k*NC +: NC] = i_rdi_pl_cfg;
         end
      end
   end

   assign last_c     = (state_q == RX_IDLE) ? (CHUNKS == 32'd1)
                                            : (cnt_q == CW'(CHUNKS - 1));
   assign complete_c = i_rdi_pl_cfg_vld && !i_flush && last_c;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q          <= RX_IDLE;
         cnt_q            <= '0;
         partial_q        <= '0;
         o_phase_received <= '0;
         o_phase_valid    <= 1'b0;
         o_busy           <= 1'b0;
         o_overrun        <= 1'b0;
      end else begin
         o_overrun <= 1'b0;

         if (i_flush) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            partial_q <= '0;
            o_busy    <= 1'b0;
         end else if (i_rdi_pl_cfg_vld) begin
            if (last_c) begin
               state_q   <= RX_IDLE;
               cnt_q     <= '0;
               partial_q <= '0;
               o_busy    <= 1'b0;
            end else begin
               state_q   <= RX_ASSEMBLE;
               cnt_q     <= cnt_q + CW'(1);
               partial_q <= phase_next_c;
               o_busy    <= 1'b1;
            end
         end

         // A completed phase replaces the held one only if the slot is free or being acked.
         if (complete_c) begin
            if (!o_phase_valid || i_phase_ack) begin
               o_phase_received <= phase_next_c;
               o_phase_valid    <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (i_phase_ack) begin
            o_phase_valid <= 1'b0;
         end
      end
   end

endmodule
